// File: rtl/concat_requant_if.sv
// Bus bundle for concat_requant: job control, credit-gated input beat and FWFT output beat.
// The design consumes the slave view; whoever feeds and drains it uses the master view.
interface concat_requant_if #(
    parameter int PICTURE_NUM       = 1,
    parameter int RE_CHANNEL_IN_NUM = 16
);
    localparam int LANES = PICTURE_NUM * RE_CHANNEL_IN_NUM;

    logic                  Start;
    logic [15:0]           Beat_Num;
    logic [4:0]            Shift;
    logic [7:0]            Zero_Point;
    logic                  Data_In_Valid;
    logic                  Data_In_Ready;
    logic [LANES*32-1:0]   Scale_Data_In;
    logic [LANES*8-1:0]    Data_Out;
    logic                  Data_Out_Valid;
    logic                  Data_Out_Ready;
    logic                  Done;

    modport master (
        output Start, Beat_Num, Shift, Zero_Point, Data_In_Valid, Scale_Data_In, Data_Out_Ready,
        input  Data_In_Ready, Data_Out, Data_Out_Valid, Done
    );

    modport slave (
        input  Start, Beat_Num, Shift, Zero_Point, Data_In_Valid, Scale_Data_In, Data_Out_Ready,
        output Data_In_Ready, Data_Out, Data_Out_Valid, Done
    );
endinterface

// File: rtl/concat_requant.sv
// Requantises scaled concat lanes to uint8 (rounding shift, zero point, saturation), tracks
// beats through the fixed-latency scale stage and buffers them in a credit-protected FWFT FIFO.
module concat_requant #(
    parameter int PICTURE_NUM       = 1,
    parameter int RE_CHANNEL_IN_NUM = 16,
    parameter int SCALE_LATENCY     = 4,
    parameter int FIFO_DEPTH        = 16
) (
    input logic             clk,
    input logic             rst_n,
    concat_requant_if.slave bus
);
    localparam int LANES = PICTURE_NUM * RE_CHANNEL_IN_NUM;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + SCALE_LATENCY + 2) + 1;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                   state_reg, state_next;
    logic                     done_reg, done_next, load_job;
    logic [15:0]              beat_num_reg, in_cnt_reg, out_cnt_reg;
    logic [4:0]               shift_reg;
    logic [7:0]               zero_point_reg;
    logic [SCALE_LATENCY-1:0] valid_line_reg;
    logic                     rq_valid_reg;
    logic [LANES*8-1:0]       rq_data_reg, rq_data_next;
    logic [LANES*8-1:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]         fifo_count_reg;
    logic [OCC_W-1:0]         occupancy;
    logic                     in_accept, out_accept, fifo_nonempty;

    // Every beat already granted but not yet read out holds a FIFO slot in reserve.
    always_comb begin
        occupancy = OCC_W'(rq_valid_reg) + OCC_W'(fifo_count_reg);
        for (int i = 0; i < SCALE_LATENCY; i++) begin
            occupancy = occupancy + OCC_W'(valid_line_reg[i]);
        end
    end

    assign bus.Data_In_Ready  = (state_reg == RUN) && (occupancy < OCC_W'(FIFO_DEPTH))
                                && (in_cnt_reg < beat_num_reg);
    assign in_accept          = bus.Data_In_Valid && bus.Data_In_Ready;
    assign fifo_nonempty      = (fifo_count_reg != '0);
    assign out_accept         = fifo_nonempty && bus.Data_Out_Ready;
    assign bus.Data_Out_Valid = fifo_nonempty;
    assign bus.Data_Out       = fifo_nonempty ? fifo_mem[rd_ptr_reg] : '0;
    assign bus.Done           = done_reg;

    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        load_job   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.Start) begin
                    if (bus.Beat_Num == 16'd0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = RUN;
                        load_job   = 1'b1;
                    end
                end
            end
            RUN: begin
                if (out_accept && (out_cnt_reg + 16'd1 == beat_num_reg)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The 33-bit sum keeps the rounding carry of x near 2^32.
    genvar gi;
    for (gi = 0; gi < LANES; gi++) begin : g_lane
        logic [32:0] rounded;
        logic [33:0] biased;
        always_comb begin
            if (shift_reg == 5'd0) begin
                rounded = {1'b0, bus.Scale_Data_In[gi*32 +: 32]};
            end else begin
                rounded = ({1'b0, bus.Scale_Data_In[gi*32 +: 32]}
                           + (33'd1 << (shift_reg - 5'd1))) >> shift_reg;
            end
            biased = {1'b0, rounded} + {26'd0, zero_point_reg};
        end
        assign rq_data_next[gi*8 +: 8] = (biased > 34'd255) ? 8'hFF : biased[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            done_reg       <= 1'b0;
            beat_num_reg   <= '0;
            shift_reg      <= '0;
            zero_point_reg <= '0;
            in_cnt_reg     <= '0;
            out_cnt_reg    <= '0;
            valid_line_reg <= '0;
            rq_valid_reg   <= 1'b0;
            rq_data_reg    <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
            if (load_job) begin
                beat_num_reg   <= bus.Beat_Num;
                shift_reg      <= bus.Shift;
                zero_point_reg <= bus.Zero_Point;
                in_cnt_reg     <= '0;
                out_cnt_reg    <= '0;
            end else begin
                if (in_accept)  in_cnt_reg  <= in_cnt_reg + 16'd1;
                if (out_accept) out_cnt_reg <= out_cnt_reg + 16'd1;
            end
            valid_line_reg <= {valid_line_reg[SCALE_LATENCY-2:0], in_accept};
            rq_valid_reg   <= valid_line_reg[SCALE_LATENCY-1];
            if (valid_line_reg[SCALE_LATENCY-1]) rq_data_reg <= rq_data_next;
            if (rq_valid_reg) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (out_accept)   rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({rq_valid_reg, out_accept})
                2'b10:   fifo_count_reg <= fifo_count_reg + CNT_W'(1);
                2'b01:   fifo_count_reg <= fifo_count_reg - CNT_W'(1);
                default: fifo_count_reg <= fifo_count_reg;
            endcase
        end
    end

    // Credit guarantees a free slot whenever the requant register holds a beat.
    always_ff @(posedge clk) begin
        if (rq_valid_reg) fifo_mem[wr_ptr_reg] <= rq_data_reg;
    end
endmodule

// File: doc/concat_requant.md
# concat_requant

Downstream stage of the concat scale multiplier in the TJPU concat path. It takes the 32-bit scaled lanes the scale stage produces, applies a rounding right shift, adds the output zero point and saturates each lane to uint8. It tracks valid data through the fixed-latency scale pipeline, buffers results in an output FIFO, and throttles its upstream feeder by credit so that no scaled beat is ever dropped. It also counts the beats of one concat job and pulses done when the last beat has been delivered.

## Interface
- RE_CHANNEL_IN_NUM, 16, channels per beat per picture; lane count is `PICTURE_NUM*RE_CHANNEL_IN_NUM` (`PICTURE_NUM` comes from the shared parameter header).
- SCALE_LATENCY, 4, cycles from data entering the scale stage to its scaled output (3 multiply + 1 judge).
- FIFO_DEPTH, 16, output FIFO entries; must be a power of 2 and at least SCALE_LATENCY+2.
- clk  in  1  single clock.
- rst_n  in  1  synchronous, active-low reset.
- Start  in  1  one-cycle pulse; loads Beat_Num and begins a job.
- Beat_Num  in  16  number of output beats in the job; sampled on Start.
- Shift  in  5  rounding right-shift amount; sampled on Start.
- Zero_Point  in  8  output zero point; sampled on Start.
- Data_In_Valid  in  1  upstream is presenting a beat to the scale stage this cycle.
- Data_In_Ready  out  1  this block grants acceptance of that beat.
- Scale_Data_In  in  `PICTURE_NUM*RE_CHANNEL_IN_NUM*32`  scaled lanes from the scale stage; lane k occupies bits [k*32+31:k*32].
- Data_Out  out  `PICTURE_NUM*RE_CHANNEL_IN_NUM*8`  requantised lanes; lane k occupies bits [k*8+7:k*8].
- Data_Out_Valid  out  1  FIFO head is valid.
- Data_Out_Ready  in  1  downstream accepts the head.
- Done  out  1  one-cycle pulse after the last beat of a job is accepted downstream.

## Operation
- FSM states are IDLE and RUN. IDLE moves to RUN on Start. RUN moves to IDLE on the output handshake where the output counter reaches Beat_Num.
- Start while in RUN is ignored.
- Start with Beat_Num=0: the block stays in IDLE and pulses Done on the next cycle.
- An input beat is accepted when Data_In_Valid && Data_In_Ready.
- A beat is accepted only in RUN, and only while the input counter is below Beat_Num. Excess upstream beats are never granted.
- Accepted beats shift a 1 into a SCALE_LATENCY-deep valid delay line. When that 1 emerges, Scale_Data_In is sampled as the matching beat.
- Requantisation, per lane, unsigned:
  - If Shift=0, r = x. Otherwise r = (x + 2^(Shift-1)) >> Shift, computed in 33 bits so the carry is not lost.
  - y = r + Zero_Point.
  - Output min(y, 255).
- The requant result is registered once, then written to the FIFO.
- The FIFO is first-word-fall-through: Data_Out is the head entry whenever Data_Out_Valid=1.
- Credit rule: Data_In_Ready = RUN && (in_flight + fifo_count < FIFO_DEPTH) && input counter < Beat_Num.
  - in_flight is the number of 1s in the delay line plus the requant register.
  - Because of this rule, a FIFO write can never find the FIFO full.
- A FIFO read and a FIFO write in the same cycle are both performed, and the count stays unchanged.

## Timing
- Reset values (rst_n=0 at a clock edge):
  - FSM goes to IDLE.
  - Counters, delay line, requant valid and FIFO pointers/count are cleared to 0.
  - Data_In_Ready=0, Data_Out_Valid=0, Done=0, Data_Out=0.
- Reset mid-job discards every in-flight and buffered beat. No Done is issued for the aborted job.
- Latency: a beat accepted at cycle t with an empty FIFO gives Data_Out_Valid=1 at cycle t+SCALE_LATENCY+2.
- Throughput is one beat per cycle while Data_Out_Ready=1.
- Data_Out and Data_Out_Valid are held stable while Data_Out_Valid=1 and Data_Out_Ready=0.
- Done asserts on the cycle after the final output handshake. The FSM is in IDLE in that same cycle.
- A new Start is accepted in the Done cycle.
- Data_In_Ready is combinational from registered state only; it has no path from Data_In_Valid.

## Test plan
- Beat_Num=8, Shift=0, Zero_Point=0, lanes=0..15, continuous valid/ready -> outputs match inputs; first Data_Out_Valid 6 cycles after the first accept; Done once, 1 cycle after the 8th handshake.
- Shift=4, Zero_Point=3 -> lane values 7, 8, 24 and 0xFFFFFFFF give outputs 3, 4, 5 and 255; x=0xFFFFFFFF must not wrap.
- Shift=0, Zero_Point=200, x=100 -> output 255.
- Beat_Num=64, Data_Out_Ready=0 for 40 cycles -> Data_In_Ready drops once the FIFO plus in-flight reaches 16; no loss or reorder is allowed after ready resumes; Done follows the 64th beat.
- Start with Beat_Num=0 -> Done the next cycle and Data_In_Ready never asserts. A second Start during RUN must not disturb the running job.
- rst_n=0 for 1 cycle with 3 beats in flight and 5 in the FIFO -> all outputs return to 0 and no Done is issued; a fresh job of Beat_Num=2 then completes normally.
